cpu_mem_arbiter: RTL

//  Sits directly below the CPU core's memory ports. Merges the instruction-fetch

---
 rtl/cpu_mem_arbiter_if.sv | 31 +++
 rtl/cpu_mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter_if.sv
// CPU-port and SRAM-port signal bundle for cpu_mem_arbiter.
// slave = arbiter view, master = CPU core plus SRAM view.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_ce;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              data_ce;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              stall_req;
  logic              sram_ce;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_ce, inst_addr, data_ce, data_we, data_addr, data_wdata, sram_rdata,
    output inst_data, data_rdata, stall_req, sram_ce, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output inst_ce, inst_addr, data_ce, data_we, data_addr, data_wdata, sram_rdata,
    input  inst_data, data_rdata, stall_req, sram_ce, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Merges the CPU fetch and data ports onto one fixed-latency single-port SRAM.
// Data accesses win; a pending fetch follows directly with no idle cycle.
module cpu_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  cpu_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // SRAM controls are loaded on the edge that enters an access state, so they
  // are already valid in that state's first cycle, exactly as a decode would be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.inst_data  <= '0;
      bus.data_rdata <= '0;
      bus.sram_ce    <= 1'b0;
      bus.sram_we    <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_ce) begin
            state          <= D_ACC;
            cnt            <= CNT_LOAD;
            bus.sram_ce    <= 1'b1;
            bus.sram_we    <= bus.data_we;
            bus.sram_addr  <= bus.data_addr;
            bus.sram_wdata <= bus.data_wdata;
          end else if (bus.inst_ce) begin
            state          <= I_ACC;
            cnt            <= CNT_LOAD;
            bus.sram_ce    <= 1'b1;
            bus.sram_we    <= 1'b0;
            bus.sram_addr  <= bus.inst_addr;
            bus.sram_wdata <= '0;
          end
        end

        D_ACC: begin
          if (cnt == '0) begin
            // Capture decision follows the access actually issued to the SRAM.
            if (!bus.sram_we) begin
              bus.data_rdata <= bus.sram_rdata;
            end
            if (bus.inst_ce) begin
              state          <= I_ACC;
              cnt            <= CNT_LOAD;
              bus.sram_ce    <= 1'b1;
              bus.sram_we    <= 1'b0;
              bus.sram_addr  <= bus.inst_addr;
              bus.sram_wdata <= '0;
            end else begin
              state          <= DONE;
              bus.sram_ce    <= 1'b0;
              bus.sram_we    <= 1'b0;
              bus.sram_addr  <= '0;
              bus.sram_wdata <= '0;
            end
          end else begin
            cnt            <= cnt - CNT_ONE;
            bus.sram_we    <= bus.data_we;
            bus.sram_addr  <= bus.data_addr;
            bus.sram_wdata <= bus.data_wdata;
          end
        end

        I_ACC: begin
          if (cnt == '0) begin
            bus.inst_data  <= bus.sram_rdata;
            state          <= DONE;
            bus.sram_ce    <= 1'b0;
            bus.sram_we    <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
          end else begin
            cnt           <= cnt - CNT_ONE;
            bus.sram_addr <= bus.inst_addr;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The IDLE term must respond in the request's first cycle, so stall_req is
  // decoded rather than registered; gating with rst keeps it 0 during reset.
  always_comb begin
    bus.stall_req = 1'b0;
    if (rst) begin
      case (state)
        IDLE:         bus.stall_req = bus.data_ce | bus.inst_ce;
        D_ACC, I_ACC: bus.stall_req = 1'b1;
        default:      bus.stall_req = 1'b0;
      endcase
    end
  end

endmodule
